// File: rtl/ex_pipeline_buffers_pkg.sv
// Shared widths and stage records for the execute-side pipeline registers.
// The BUBBLE constant is the canonical empty ID/EX entry.
package ex_pipeline_buffers_pkg;

    localparam int REG_W  = 3;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic             valid;
        logic             wb;
        logic             mem_read;
        logic [REG_W-1:0] src;
        logic [REG_W-1:0] dst;
    } stage_t;

    // Later stages only need what forwarding and load-data selection consume
    typedef struct packed {
        logic             valid;
        logic             wb;
        logic             mem_read;
        logic [REG_W-1:0] dst;
    } mem_stage_t;

    typedef struct packed {
        logic             valid;
        logic             wb;
        logic [REG_W-1:0] dst;
    } wb_stage_t;

    localparam stage_t BUBBLE = '0;

endpackage

// File: rtl/ex_pipeline_buffers_if.sv
// Bundle between decode/execute/memory and the pipeline buffers; buffers are the slave.
// Outputs feed forwarding_unit and the fetch/decode stall.
interface ex_pipeline_buffers_if;
    import ex_pipeline_buffers_pkg::*;

    logic              id_valid;
    logic [REG_W-1:0]  id_src;
    logic [REG_W-1:0]  id_dst;
    logic              id_wb;
    logic              id_mem_read;
    logic              flush;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] mem_rdata;

    logic [REG_W-1:0]  instruction_src;
    logic [REG_W-1:0]  instruction_dst;
    logic [REG_W-1:0]  buf1_dst;
    logic [REG_W-1:0]  buf2_dst;
    logic              wb_buf1;
    logic              wb_buf2;
    logic [DATA_W-1:0] buf1_alu_result;
    logic [DATA_W-1:0] buf2_wb_data;
    logic              stall;

    modport master (
        output id_valid, id_src, id_dst, id_wb, id_mem_read, flush, ex_result, mem_rdata,
        input  instruction_src, instruction_dst, buf1_dst, buf2_dst,
               wb_buf1, wb_buf2, buf1_alu_result, buf2_wb_data, stall
    );

    modport slave (
        input  id_valid, id_src, id_dst, id_wb, id_mem_read, flush, ex_result, mem_rdata,
        output instruction_src, instruction_dst, buf1_dst, buf2_dst,
               wb_buf1, wb_buf2, buf1_alu_result, buf2_wb_data, stall
    );

endinterface

// File: rtl/ex_pipeline_buffers_load_use_detector.sv
// Combinational load-use hazard against the load sitting in ID/EX; zero latency.
// A same-cycle flush suppresses the stall since the dependent instruction dies anyway.
module ex_pipeline_buffers_load_use_detector
    import ex_pipeline_buffers_pkg::*;
(
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src,
    input  logic [REG_W-1:0] id_dst,
    input  logic             idex_valid,
    input  logic             idex_wb,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_dst,
    input  logic             flush,
    output logic             stall
);

    logic hazard;

    // id_dst is also a read operand, so it participates in the match
    always_comb begin
        hazard = id_valid && idex_valid && idex_mem_read && idex_wb &&
                 ((id_src == idex_dst) || (id_dst == idex_dst));
        stall  = hazard && !flush;
    end

endmodule

// File: rtl/ex_pipeline_buffers.sv
// ID/EX, EX/MEM and MEM/WB registers with load-use stall; ID/EX to MEM/WB in 2 cycles.
// No back-pressure past ID/EX; a stall or flush only swaps the ID/EX entry for a bubble.
module ex_pipeline_buffers
    import ex_pipeline_buffers_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    ex_pipeline_buffers_if.slave bus
);

    stage_t            idex_d,      idex_q;
    mem_stage_t        buf1_d,      buf1_q;
    wb_stage_t         buf2_d,      buf2_q;
    logic [DATA_W-1:0] buf1_alu_d,  buf1_alu_q;
    logic [DATA_W-1:0] buf2_data_d, buf2_data_q;
    logic              stall;

    ex_pipeline_buffers_load_use_detector u_load_use_detector (
        .id_valid      (bus.id_valid),
        .id_src        (bus.id_src),
        .id_dst        (bus.id_dst),
        .idex_valid    (idex_q.valid),
        .idex_wb       (idex_q.wb),
        .idex_mem_read (idex_q.mem_read),
        .idex_dst      (idex_q.dst),
        .flush         (bus.flush),
        .stall         (stall)
    );

    always_comb begin
        idex_d = BUBBLE;
        if (bus.id_valid && !bus.flush && !stall) begin
            idex_d = '{valid: 1'b1, wb: bus.id_wb, mem_read: bus.id_mem_read,
                       src: bus.id_src, dst: bus.id_dst};
        end

        buf1_d     = '{valid: idex_q.valid, wb: idex_q.wb,
                       mem_read: idex_q.mem_read, dst: idex_q.dst};
        buf1_alu_d = idex_q.valid ? bus.ex_result : '0;

        buf2_d      = '{valid: buf1_q.valid, wb: buf1_q.wb, dst: buf1_q.dst};
        buf2_data_d = '0;
        if (buf1_q.valid) begin
            buf2_data_d = buf1_q.mem_read ? bus.mem_rdata : buf1_alu_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= BUBBLE;
            buf1_q      <= '0;
            buf2_q      <= '0;
            buf1_alu_q  <= '0;
            buf2_data_q <= '0;
        end else begin
            idex_q      <= idex_d;
            buf1_q      <= buf1_d;
            buf2_q      <= buf2_d;
            buf1_alu_q  <= buf1_alu_d;
            buf2_data_q <= buf2_data_d;
        end
    end

    assign bus.instruction_src = idex_q.src;
    assign bus.instruction_dst = idex_q.dst;
    assign bus.buf1_dst        = buf1_q.dst;
    assign bus.buf2_dst        = buf2_q.dst;
    assign bus.wb_buf1         = buf1_q.valid && buf1_q.wb;
    assign bus.wb_buf2         = buf2_q.valid && buf2_q.wb;
    assign bus.buf1_alu_result = buf1_alu_q;
    assign bus.buf2_wb_data    = buf2_data_q;
    assign bus.stall           = stall;

endmodule

// File: tb/tb_ex_pipeline_buffers.sv
// Directed vector bench for ex_pipeline_buffers: stall is checked before each edge,
// registered outputs just after it.
module tb_ex_pipeline_buffers;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_pipeline_buffers_if bus ();

    ex_pipeline_buffers dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]  isrc;
        logic [2:0]  idst;
        logic [2:0]  b1dst;
        logic [2:0]  b2dst;
        logic        wb1;
        logic        wb2;
        logic [15:0] alu;
        logic [15:0] wbd;
    } obs_t;

    typedef struct {
        string       name;
        logic        rst;
        logic        vld;
        logic [2:0]  src;
        logic [2:0]  dst;
        logic        wb;
        logic        mr;
        logic        fl;
        logic [15:0] exr;
        logic [15:0] mrd;
        logic        chk_stall;
        logic        e_stall;
        obs_t        e;
    } vec_t;

    int applied     = 0;
    int miscompares = 0;

    function automatic obs_t ob(input logic [2:0] isrc, input logic [2:0] idst,
                                input logic [2:0] b1, input logic [2:0] b2,
                                input logic wb1, input logic wb2,
                                input logic [15:0] alu, input logic [15:0] wbd);
        ob = '{isrc: isrc, idst: idst, b1dst: b1, b2dst: b2,
               wb1: wb1, wb2: wb2, alu: alu, wbd: wbd};
    endfunction

    function automatic vec_t mk(input string name, input logic r, input logic vld,
                                input logic [2:0] src, input logic [2:0] dst,
                                input logic wb, input logic mr, input logic fl,
                                input logic [15:0] exr, input logic [15:0] mrd,
                                input logic cs, input logic es, input obs_t e);
        mk.name = name; mk.rst = r; mk.vld = vld; mk.src = src; mk.dst = dst;
        mk.wb = wb; mk.mr = mr; mk.fl = fl; mk.exr = exr; mk.mrd = mrd;
        mk.chk_stall = cs; mk.e_stall = es; mk.e = e;
    endfunction

    task automatic apply(input vec_t v);
        obs_t got;
        rst             = v.rst;
        bus.id_valid    = v.vld;
        bus.id_src      = v.src;
        bus.id_dst      = v.dst;
        bus.id_wb       = v.wb;
        bus.id_mem_read = v.mr;
        bus.flush       = v.fl;
        bus.ex_result   = v.exr;
        bus.mem_rdata   = v.mrd;
        @(negedge clk);
        if (v.chk_stall) begin
            applied++;
            if (bus.stall !== v.e_stall) begin
                miscompares++;
                $display("FAIL %s stall: got %b want %b", v.name, bus.stall, v.e_stall);
            end
        end
        @(posedge clk);
        #1;
        got = ob(bus.instruction_src, bus.instruction_dst, bus.buf1_dst, bus.buf2_dst,
                 bus.wb_buf1, bus.wb_buf2, bus.buf1_alu_result, bus.buf2_wb_data);
        applied++;
        if (got !== v.e) begin
            miscompares++;
            $display("FAIL %s outputs {isrc,idst,b1,b2,wb1,wb2,alu,wbd}: got %h want %h",
                     v.name, got, v.e);
        end
    endtask

    vec_t tbl[$];

    initial begin
        //                 name         rst vld src dst wb mr fl exr       mrd       cs es  isrc idst b1 b2 wb1 wb2 alu     wbd
        tbl.push_back(mk("rst_a",      1, 1, 0, 5, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, ob(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        tbl.push_back(mk("rst_b",      1, 1, 0, 5, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        tbl.push_back(mk("rst_rel",    0, 1, 0, 5, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 5, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        tbl.push_back(mk("add_r3",     0, 1, 0, 3, 1, 0, 0, 16'h0055, 16'h0000, 1, 0, ob(0, 3, 5, 0, 1, 0, 16'h0055, 16'h0000)));
        tbl.push_back(mk("add_ex",     0, 0, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 1, 0, ob(0, 0, 3, 5, 1, 1, 16'h1234, 16'h0055)));
        tbl.push_back(mk("add_mem",    0, 0, 0, 0, 0, 0, 0, 16'h7777, 16'hAAAA, 1, 0, ob(0, 0, 0, 3, 0, 1, 16'h0000, 16'h1234)));
        tbl.push_back(mk("drain_a",    0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        tbl.push_back(mk("ld_r2",      0, 1, 1, 2, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, ob(1, 2, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        tbl.push_back(mk("use_r2",     0, 1, 2, 3, 1, 0, 0, 16'h0100, 16'h0000, 1, 1, ob(0, 0, 2, 0, 1, 0, 16'h0100, 16'h0000)));
        tbl.push_back(mk("use_r2_re",  0, 1, 2, 3, 1, 0, 0, 16'h9999, 16'hBEEF, 1, 0, ob(2, 3, 0, 2, 0, 1, 16'h0000, 16'hBEEF)));
        tbl.push_back(mk("use_ex",     0, 0, 0, 0, 0, 0, 0, 16'h0042, 16'h0000, 1, 0, ob(0, 0, 3, 0, 1, 0, 16'h0042, 16'h0000)));
        tbl.push_back(mk("use_mem",    0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 0, 0, 3, 0, 1, 16'h0000, 16'h0042)));
        tbl.push_back(mk("ld_r4",      0, 1, 0, 4, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 4, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        tbl.push_back(mk("dst_haz",    0, 1, 5, 4, 1, 0, 0, 16'h0200, 16'h0000, 1, 1, ob(0, 0, 4, 0, 1, 0, 16'h0200, 16'h0000)));
        tbl.push_back(mk("ld_r4_b",    0, 1, 0, 4, 1, 1, 0, 16'h0000, 16'h1111, 1, 0, ob(0, 4, 0, 4, 0, 1, 16'h0000, 16'h1111)));
        tbl.push_back(mk("no_haz",     0, 1, 1, 6, 1, 0, 0, 16'h0300, 16'h0000, 1, 0, ob(1, 6, 4, 0, 1, 0, 16'h0300, 16'h0000)));
        tbl.push_back(mk("alu_r4",     0, 1, 0, 4, 1, 0, 0, 16'h0006, 16'h2222, 1, 0, ob(0, 4, 6, 4, 1, 1, 16'h0006, 16'h2222)));
        tbl.push_back(mk("alu_use",    0, 1, 4, 7, 1, 0, 0, 16'h0004, 16'h0000, 1, 0, ob(4, 7, 4, 6, 1, 1, 16'h0004, 16'h0006)));
        tbl.push_back(mk("alu_ex",     0, 0, 0, 0, 0, 0, 0, 16'h0007, 16'h0000, 1, 0, ob(0, 0, 7, 4, 1, 1, 16'h0007, 16'h0004)));
        tbl.push_back(mk("alu_mem",    0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 0, 0, 7, 0, 1, 16'h0000, 16'h0007)));
        tbl.push_back(mk("ld_r2_f",    0, 1, 0, 2, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 2, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        tbl.push_back(mk("flush_haz",  0, 1, 2, 5, 1, 0, 1, 16'h0050, 16'h0000, 1, 0, ob(0, 0, 2, 0, 1, 0, 16'h0050, 16'h0000)));
        tbl.push_back(mk("flush_mem",  0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h3333, 1, 0, ob(0, 0, 0, 2, 0, 1, 16'h0000, 16'h3333)));
        tbl.push_back(mk("flush_alu",  0, 1, 1, 1, 1, 0, 1, 16'h0000, 16'h0000, 1, 0, ob(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000)));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset while a load sits in buf1: everything in flight is dropped
        apply(mk("mid_ld",     0, 1, 0, 3, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 3, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        apply(mk("mid_adv",    0, 0, 0, 0, 0, 0, 0, 16'h0010, 16'h0000, 1, 0, ob(0, 0, 3, 0, 1, 0, 16'h0010, 16'h0000)));
        apply(mk("mid_rst",    1, 1, 3, 1, 1, 0, 0, 16'h0000, 16'h5555, 1, 0, ob(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000)));
        apply(mk("mid_rel",    0, 1, 3, 1, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, ob(3, 1, 0, 0, 0, 0, 16'h0000, 16'h0000)));

        // A load that does not write back never stalls; id_valid=0 never stalls
        apply(mk("ld_nowb",    0, 1, 0, 2, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 2, 1, 0, 1, 0, 16'h0000, 16'h0000)));
        apply(mk("nowb_use",   0, 1, 2, 2, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, ob(2, 2, 2, 1, 0, 1, 16'h0000, 16'h0000)));
        apply(mk("ld_r6",      0, 1, 0, 6, 1, 1, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 6, 2, 2, 1, 0, 16'h0000, 16'h0000)));
        apply(mk("novld_r6",   0, 0, 6, 6, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, ob(0, 0, 6, 2, 1, 1, 16'h0000, 16'h0000)));

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
